// File: rtl/sobel_stream_ctrl_if.sv
`default_nettype none
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
// ============================================================================
//  Module      : sobel_stream_ctrl_if
//  Description : Pixel-in / result-out stream bundle for sobel_stream_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
interface sobel_stream_ctrl_if #(
    parameter int W = `WORD_SIZE
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    // master: the pixel source / result sink around the controller
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/sobel_stream_ctrl.sv
`default_nettype none
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
// ============================================================================
//  Module      : sobel_stream_ctrl
//  Description : Raster pixel stream to 3x3 Sobel window controller with
//                two line buffers, result handshake and frame sequencing.
//  Revision    : 1.0  initial release
// ============================================================================
module sobel_stream_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    sobel_stream_ctrl_if.slave     bus,
    output logic                   win_en,
    output logic [`WORD_SIZE-1:0]  win_p1,
    output logic [`WORD_SIZE-1:0]  win_p2,
    output logic [`WORD_SIZE-1:0]  win_p3,
    output logic [`WORD_SIZE-1:0]  win_p4,
    output logic [`WORD_SIZE-1:0]  win_p5,
    output logic [`WORD_SIZE-1:0]  win_p6,
    output logic [`WORD_SIZE-1:0]  win_p7,
    output logic [`WORD_SIZE-1:0]  win_p8,
    output logic [`WORD_SIZE-1:0]  win_p9,
    input  logic [`WORD_SIZE-1:0]  sobel_q,
    output logic                   frame_done
);

    localparam int W  = `WORD_SIZE;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] c_col_last = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] c_row_last = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] c_col_two  = CW'(2);
    localparam logic [RW-1:0] c_row_two  = RW'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_frame_done;

    logic [W-1:0]  r_lb1 [IMG_WIDTH];
    logic [W-1:0]  r_lb2 [IMG_WIDTH];
    logic [W-1:0]  r_win [3][3];

    logic [W-1:0]  w_shift [3][3];
    logic [W-1:0]  w_view  [3][3];
    logic [W-1:0]  w_lb1_rd;
    logic [W-1:0]  w_lb2_rd;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_win_en;
    logic          w_col_last;
    logic          w_frame_last;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;

    assign w_in_ready   = !reset && (r_state != S_DRAIN) && (!r_out_valid || bus.out_ready);
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_win_en     = w_accept && (r_row >= c_row_two) && (r_col >= c_col_two);
    assign w_col_last   = (r_col == c_col_last);
    assign w_frame_last = w_col_last && (r_row == c_row_last);
    assign w_col_nxt    = w_col_last ? '0 : r_col + 1'b1;
    assign w_row_nxt    = w_col_last ? r_row + 1'b1 : r_row;

    assign w_lb1_rd = r_lb1[r_col];
    assign w_lb2_rd = r_lb2[r_col];

    // The window seen on an accept is the registered window shifted left with
    // the new column appended; otherwise the last window is held so it stays
    // stable while a result is stalled downstream.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_shift[i][0] = r_win[i][1];
            w_shift[i][1] = r_win[i][2];
        end
        w_shift[0][2] = w_lb2_rd;
        w_shift[1][2] = w_lb1_rd;
        w_shift[2][2] = bus.in_data;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_view[i][j] = w_accept ? w_shift[i][j] : r_win[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_win        <= '{default: '0};
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_accept) begin
                r_win <= w_shift;
                if (w_frame_last) begin
                    r_col   <= '0;
                    r_row   <= '0;
                    r_state <= S_DRAIN;
                end else begin
                    r_col   <= w_col_nxt;
                    r_row   <= w_row_nxt;
                    r_state <= ((w_row_nxt >= c_row_two) && (w_col_nxt >= c_col_two)) ? S_RUN : S_FILL;
                end
            end

            if (r_state == S_DRAIN && r_out_valid && bus.out_ready && r_out_last) begin
                r_state      <= S_IDLE;
                r_frame_done <= 1'b1;
            end

            if (w_win_en) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_frame_last;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    // Line buffers are plain storage: rows 0 and 1 of every frame rewrite
    // them before any window reads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= w_lb1_rd;
            r_lb1[r_col] <= bus.in_data;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = sobel_q;
    assign bus.out_last  = r_out_last;
    assign win_en        = w_win_en;
    assign frame_done    = r_frame_done;

    assign win_p1 = w_view[0][0];
    assign win_p2 = w_view[0][1];
    assign win_p3 = w_view[0][2];
    assign win_p4 = w_view[1][0];
    assign win_p5 = w_view[1][1];
    assign win_p6 = w_view[1][2];
    assign win_p7 = w_view[2][0];
    assign win_p8 = w_view[2][1];
    assign win_p9 = w_view[2][2];

endmodule
`default_nettype wire
